// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the sync_fifo_flex family.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // DEPTH must be a power of two >= 2; thresholds must fall inside the usable count range.
    function automatic bit fifo_params_ok(input int depth, input int afull_th, input int aempty_th);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: one write port, one read port. The read port is registered
// by default and combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rst ^ re;
    assign rdata = mem[raddr];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
`endif

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with count, almost flags, sticky error flags and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   winc,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   wfull,
    output logic                   walmost_full,
    input  logic                   rinc,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic                   rempty,
    output logic                   ralmost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

    if (!fifo_params_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("sync_fifo_flex: illegal DEPTH/AFULL_TH/AEMPTY_TH");
    end

    logic [AW:0] wptr, rptr;
    logic        wr_ok, rd_ok;

    // Flags decode registered state only, never the request inputs.
    assign wfull         = (count == FULL_C);
    assign rempty        = (count == '0);
    assign walmost_full  = (count >= AFULL_C);
    assign ralmost_empty = (count <= AEMPTY_C);

    assign wr_ok = winc && !wfull && !clr;
    assign rd_ok = rinc && !rempty && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rvalid = !rempty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rvalid <= 1'b0;
        else if (clr) rvalid <= 1'b0;
        else          rvalid <= rd_ok;
    end
`endif

    sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomised and directed checks of sync_fifo_flex against a queue-based reference model.
module tb_sync_fifo_flex;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;
    localparam int AET   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       winc = 1'b0;
    logic [7:0] wdata = '0;
    logic       rinc = 1'b0;
    logic       wfull, walmost_full, rvalid, rempty, ralmost_empty, overflow, underflow;
    logic [7:0] rdata;
    logic [3:0] count;

    sync_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
        .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata), .wfull(wfull),
        .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rvalid(rvalid),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // reference model
    logic [7:0] q[$];
    bit         m_ovf = 0, m_unf = 0, m_rvalid = 0;
    logic [7:0] m_rdata = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic model_edge(input bit w, input logic [7:0] d, input bit r, input bit c);
        int n;
        n = q.size();
        if (c) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rvalid = 0;
        end else begin
            if (w && n == DEPTH) m_ovf = 1;
            if (r && n == 0)     m_unf = 1;
            m_rvalid = r && n > 0;
            if (r && n > 0) m_rdata = q.pop_front();
            if (w && n < DEPTH) q.push_back(d);
        end
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
        winc = w; wdata = d; rinc = r; clr = c;
        @(posedge clk);
        model_edge(w, d, r, c);
        @(negedge clk);
        winc = 0; rinc = 0; clr = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_wfull"}, int'(wfull), 0);
        chk({tag, "_rempty"}, int'(rempty), 1);
        chk({tag, "_ralmost_empty"}, int'(ralmost_empty), 1);
        chk({tag, "_walmost_full"}, int'(walmost_full), 0);
        chk({tag, "_rvalid"}, int'(rvalid), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_unf"}, int'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk({tag, "_rdata"}, int'(rdata), 0);
`endif
    endtask

    // asynchronous reset pulse away from any clock edge; outputs must react at once
    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        model_reset();
        #1 rst = 1'b0;
    endtask

    // single compare process: DUT vs model on every cycle
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("count", int'(count), q.size());
            chk("wfull", int'(wfull), int'(q.size() == DEPTH));
            chk("rempty", int'(rempty), int'(q.size() == 0));
            chk("walmost_full", int'(walmost_full), int'(q.size() >= AFT));
            chk("ralmost_empty", int'(ralmost_empty), int'(q.size() <= AET));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
            chk("rvalid", int'(rvalid), int'(q.size() > 0));
            if (q.size() > 0) chk("rdata", int'(rdata), int'(q[0]));
`else
            chk("rvalid", int'(rvalid), int'(m_rvalid));
            chk("rdata", int'(rdata), int'(m_rdata));
`endif
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // fill
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(8'h10 + i), 0, 0);
            if (i == 4) chk("fill_afull_at5", int'(walmost_full), 0);
            if (i == 5) chk("fill_afull_at6", int'(walmost_full), 1);
        end
        chk("fill_count", int'(count), 8);
        chk("fill_wfull", int'(wfull), 1);
        step(1, 8'hEE, 0, 0);
        chk("fill_ovf", int'(overflow), 1);
        chk("fill_count9", int'(count), 8);

        // drain
        for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("drain_fwft_data", int'(rdata), 8'h10 + i);
            step(0, 0, 1, 0);
`else
            step(0, 0, 1, 0);
            chk("drain_rvalid", int'(rvalid), 1);
            chk("drain_data", int'(rdata), 8'h10 + i);
`endif
        end
        chk("drain_rempty", int'(rempty), 1);
        chk("drain_raempty", int'(ralmost_empty), 1);
        step(0, 0, 1, 0);
        chk("drain_unf", int'(underflow), 1);
        step(0, 0, 0, 1);

        // wrap
        for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0, 0);
        chk("wrap_peak", int'(count), 8);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        chk("wrap_empty", int'(count), 0);

        // simultaneous
        for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h50 + i), 1, 0);
        chk("sim_cnt3", int'(count), 3);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0);
        step(1, 8'h70, 1, 0);
        chk("sim_full_cnt", int'(count), 7);
        chk("sim_full_ovf", int'(overflow), 1);
        step(0, 0, 0, 1);
        step(1, 8'h71, 1, 0);
        chk("sim_empty_cnt", int'(count), 1);
        chk("sim_empty_unf", int'(underflow), 1);

        // flush with concurrent write
        for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 0);
        chk("flush_pre", int'(count), 5);
        step(1, 8'h99, 0, 1);
        chk("flush_count", int'(count), 0);
        chk("flush_rempty", int'(rempty), 1);
        chk("flush_unf", int'(underflow), 0);
        chk("flush_rvalid", int'(rvalid), 0);

        // burst then async reset mid-burst
        for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), i[0], 0);
        pulse_rst();

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int pw;
            case ((i / 250) % 4)
                0: pw = 80;
                1: pw = 20;
                default: pw = 50;
            endcase
            step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
                 $urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) pulse_rst();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO: configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush, and a compile-time first-word-fall-through (FWFT) read mode. It sits between same-clock producer and consumer blocks wherever buffering with back-pressure and early-warning flags is needed.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, storage capacity in words. Must be a power of two and ≥2.
- AFULL_TH, DEPTH-2, almost-full threshold. Legal range is 1..DEPTH.
- AEMPTY_TH, 1, almost-empty threshold. Legal range is 0..DEPTH-1.

Ports (AW = log2(DEPTH)):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- winc  in  1  write request.
- wdata  in  WIDTH  write data.
- wfull  out  1  FIFO holds DEPTH words.
- walmost_full  out  1  count ≥ AFULL_TH.
- rinc  in  1  read request (pop).
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata is valid (see Operation).
- rempty  out  1  count == 0.
- ralmost_empty  out  1  count ≤ AEMPTY_TH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.
- underflow  out  1  sticky flag: a read was attempted while empty.

## Operation
- Accepted write: winc && !wfull. Accepted read: rinc && !rempty. Unaccepted requests change no storage, pointer or count.
- Pointers are AW+1 bits wide and wrap modulo 2·DEPTH. The memory address is the low AW bits.
- count next value:
  - +1 on a write only.
  - −1 on a read only.
  - unchanged on both or neither.
- Full with simultaneous winc and rinc: only the read is accepted, and overflow is set. There is no pass-through when full.
- Empty with simultaneous winc and rinc: only the write is accepted, and underflow is set.
- wfull, rempty, walmost_full and ralmost_empty decode the registered count/pointers only. They never decode request inputs.
- overflow is set by winc && wfull. underflow is set by rinc && rempty. Both stay set until rst or clr.
- clr has priority over winc/rinc in the same cycle. It zeroes pointers, count, overflow, underflow and rvalid. Memory contents are not cleared. rdata holds its value.
- rst has the same effect as clr, asynchronously, and also zeroes rdata.
- Reset values:
  - count=0, wfull=0, rempty=1, ralmost_empty=1.
  - walmost_full=0.
  - rvalid=0, rdata=0, overflow=0, underflow=0.

## Timing
- Standard mode (macro undefined):
  - An accepted read at edge N registers mem[rptr] into rdata at edge N. rvalid=1 for exactly the cycle after edge N.
  - rdata holds its value when there is no accepted read.
  - Latency is 1 cycle.
- Flags update in the cycle after the causing edge.
- Write-to-read turnaround, standard mode:
  - Write accepted at edge N, so rempty=0 after edge N.
  - The earliest accepted read is at edge N+1, with data valid after edge N+1.
- Back-to-back reads at consecutive edges produce one word per cycle, with rvalid continuously 1.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rdata continuously shows mem[rptr].
  - rvalid = !rempty.
  - rinc pops the shown word. The next word appears after the same edge.
  - A word written at edge N is visible on rdata after edge N (0-cycle read latency).
  - rdata after rst is don't-care while rvalid=0.
- SYNC_FIFO_FWFT_EN undefined: standard registered-read behaviour as in Timing.
- Capacity is DEPTH in both modes. All other behaviour is identical.

## Structure
- Package sync_fifo_pkg holds:
  - a clog2 helper function.
  - default WIDTH/DEPTH constants.
  - an elaboration check function for parameter legality (power-of-two DEPTH, threshold ranges).
- Sub-module sync_fifo_mem: DEPTH×WIDTH dual-port register array with one write port and one read port.
  - The read port is registered with read-enable in standard mode and combinational in FWFT mode, selected by the same macro.
  - The top level owns pointers, count, flags and the rvalid register.

## Test plan
Configuration for all scenarios: WIDTH=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=1. Run each in both macro settings where read timing differs.
- Fill: 8 writes 0x10..0x17 with no reads. Required: walmost_full rises when count reaches 6; wfull=1 and count=8 after the 8th write. A 9th winc sets overflow, and count stays 8.
- Drain after fill: 8 reads return 0x10..0x17 in order. Required: standard mode has rvalid one cycle after each accepted read; FWFT has 0x10 on rdata before the first rinc. Finally rempty=1 and ralmost_empty=1. A further rinc sets underflow.
- Wrap: 5 writes, 5 reads, then 8 writes and 8 reads. Required: data order preserved across the pointer wrap, and count peaks at exactly 8.
- Simultaneous ops: at count=3, winc+rinc for 10 cycles, count stays 3. At count=8, winc+rinc: the read is accepted, overflow=1, count=7. At count=0, winc+rinc: the write is accepted, underflow=1, count=1.
- Flush/reset: at count=5 assert clr together with winc. Required: after the edge count=0, rempty=1, flags=0, rvalid=0. Pulse rst asynchronously mid-burst: outputs take reset values immediately, without waiting for a clock edge.
